// File: rtl/fec_enc_tx_buffer.sv
// rtl/fec_enc_tx_buffer.sv - store-and-forward frame buffer between the FEC encoder fabric source and a stalling consumer
module fec_enc_tx_buffer #(
    parameter int g_depth      = 1024,
    parameter int g_max_frames = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [1:0]  snk_sel_i,
    input  logic [15:0] snk_dat_i,
    output logic        snk_stall_o,
    output logic        snk_ack_o,
    output logic        src_cyc_o,
    output logic        src_stb_o,
    output logic        src_we_o,
    output logic [1:0]  src_adr_o,
    output logic [1:0]  src_sel_o,
    output logic [15:0] src_dat_o,
    input  logic        src_stall_i,
    input  logic        src_ack_i,
    output logic [15:0] cnt_fwd_o,
    output logic [15:0] cnt_drop_o
);
    localparam int AW = $clog2(g_depth);
    localparam int PW = AW + 1;
    localparam int FW = $clog2(g_max_frames);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISCARD} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_SEND, R_WAIT_ACK} rstate_t;

    logic [19:0]   ram  [g_depth];
    logic [PW-1:0] desc [g_max_frames];

    wstate_t       wstate;
    rstate_t       rstate;
    logic [PW-1:0] wr_ptr_tmp, wr_ptr_commit, len, rd_ptr, rem, rd_addr;
    logic [FW:0]   desc_wptr, desc_rptr;
    logic [OW-1:0] outst, out_next;
    logic          silent;
    logic          accept, wfull, store_en, commit_en, desc_full, desc_empty;
    logic          issue, ack_v, load;
    logic          unused_we;

    assign unused_we = snk_we_i;
    assign src_we_o  = src_cyc_o;

    assign accept     = snk_cyc_i & snk_stb_i & ~snk_stall_o;
    assign wfull      = (wr_ptr_tmp[AW] != rd_ptr[AW]) && (wr_ptr_tmp[AW-1:0] == rd_ptr[AW-1:0]);
    assign store_en   = accept && (wstate != W_DISCARD) && !wfull;
    assign desc_full  = (desc_wptr[FW] != desc_rptr[FW]) && (desc_wptr[FW-1:0] == desc_rptr[FW-1:0]);
    assign desc_empty = (desc_wptr == desc_rptr);
    assign commit_en  = (wstate == W_RECV) && !snk_cyc_i && (len != '0) && !desc_full;

    always_ff @(posedge clk_i) begin
        if (store_en)
            ram[wr_ptr_tmp[AW-1:0]] <= {snk_adr_i, snk_sel_i, snk_dat_i};
        if (commit_en)
            desc[desc_wptr[FW-1:0]] <= len;
    end

    // wr_ptr_tmp always equals wr_ptr_commit in IDLE, so a word arriving with the rising cyc needs no special case
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wstate        <= snk_cyc_i ? W_DISCARD : W_IDLE;
            silent        <= 1'b1;
            wr_ptr_tmp    <= '0;
            wr_ptr_commit <= '0;
            len           <= '0;
            desc_wptr     <= '0;
            snk_ack_o     <= 1'b0;
            snk_stall_o   <= 1'b1;
            cnt_drop_o    <= '0;
        end else begin
            snk_stall_o <= 1'b0;
            snk_ack_o   <= accept;
            if (commit_en)
                desc_wptr <= desc_wptr + 1'b1;
            case (wstate)
                W_IDLE: begin
                    if (snk_cyc_i) begin
                        wstate <= W_RECV;
                        if (accept && wfull) begin
                            wstate <= W_DISCARD;
                            silent <= 1'b0;
                        end else if (accept) begin
                            wr_ptr_tmp <= wr_ptr_tmp + PW'(1);
                            len        <= PW'(1);
                        end
                    end
                end
                W_RECV: begin
                    if (!snk_cyc_i) begin
                        if (len != '0 && desc_full)
                            cnt_drop_o <= cnt_drop_o + 16'd1;
                        if (commit_en)
                            wr_ptr_commit <= wr_ptr_tmp;
                        else
                            wr_ptr_tmp <= wr_ptr_commit;
                        len    <= '0;
                        wstate <= W_IDLE;
                    end else if (accept && wfull) begin
                        wstate <= W_DISCARD;
                        silent <= 1'b0;
                    end else if (accept) begin
                        wr_ptr_tmp <= wr_ptr_tmp + PW'(1);
                        len        <= len + PW'(1);
                    end
                end
                W_DISCARD: begin
                    if (!snk_cyc_i) begin
                        if (!silent)
                            cnt_drop_o <= cnt_drop_o + 16'd1;
                        wr_ptr_tmp <= wr_ptr_commit;
                        len        <= '0;
                        silent     <= 1'b0;
                        wstate     <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    assign issue    = (rstate == R_SEND) && !src_stall_i;
    assign ack_v    = src_ack_i && src_cyc_o && ((outst != '0) || issue);
    assign out_next = outst + OW'(issue) - OW'(ack_v);
    assign rd_addr  = issue ? rd_ptr + PW'(1) : rd_ptr;
    assign load     = ((rstate == R_IDLE) && !desc_empty) || issue;

    // Output word register doubles as the RAM read register: it is prefetched at the pop and after every issue
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rstate    <= R_IDLE;
            src_cyc_o <= 1'b0;
            src_stb_o <= 1'b0;
            src_adr_o <= '0;
            src_sel_o <= '0;
            src_dat_o <= '0;
            rd_ptr    <= '0;
            rem       <= '0;
            outst     <= '0;
            desc_rptr <= '0;
            cnt_fwd_o <= '0;
        end else begin
            outst <= out_next;
            if (load)
                {src_adr_o, src_sel_o, src_dat_o} <= ram[rd_addr[AW-1:0]];
            case (rstate)
                R_IDLE: begin
                    if (!desc_empty) begin
                        rem       <= desc[desc_rptr[FW-1:0]];
                        desc_rptr <= desc_rptr + 1'b1;
                        src_cyc_o <= 1'b1;
                        src_stb_o <= 1'b1;
                        rstate    <= R_SEND;
                    end
                end
                R_SEND: begin
                    if (issue) begin
                        rd_ptr <= rd_ptr + PW'(1);
                        rem    <= rem - PW'(1);
                        if (rem == PW'(1)) begin
                            src_stb_o <= 1'b0;
                            rstate    <= R_WAIT_ACK;
                        end
                    end
                end
                R_WAIT_ACK: begin
                    if (out_next == '0) begin
                        src_cyc_o <= 1'b0;
                        cnt_fwd_o <= cnt_fwd_o + 16'd1;
                        rstate    <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fec_enc_tx_buffer.sv
// tb/tb_fec_enc_tx_buffer.sv - scoreboard bench for fec_enc_tx_buffer (default instance and a small 64/2 instance)
module tb_fec_enc_tx_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, sel_b;
    logic        snk_cyc, snk_stb, snk_we;
    logic [1:0]  snk_adr, snk_sel;
    logic [15:0] snk_dat;
    logic        src_stall, src_ack;

    logic        a_stall, a_ack, a_cyc, a_stb, a_we, b_stall, b_ack, b_cyc, b_stb, b_we;
    logic [1:0]  a_adr, a_sel, b_adr, b_sel;
    logic [15:0] a_dat, a_fwd, a_drop, b_dat, b_fwd, b_drop;

    logic        m_stall, m_ack, m_cyc, m_stb;
    logic [19:0] m_word;
    logic [15:0] m_fwd, m_drop;

    assign m_stall = sel_b ? b_stall : a_stall;
    assign m_ack   = sel_b ? b_ack : a_ack;
    assign m_cyc   = sel_b ? b_cyc : a_cyc;
    assign m_stb   = sel_b ? b_stb : a_stb;
    assign m_word  = sel_b ? {b_adr, b_sel, b_dat} : {a_adr, a_sel, a_dat};
    assign m_fwd   = sel_b ? b_fwd : a_fwd;
    assign m_drop  = sel_b ? b_drop : a_drop;

    fec_enc_tx_buffer dut_a (
        .clk_i(clk), .rst_i(rst_a),
        .snk_cyc_i(snk_cyc), .snk_stb_i(snk_stb), .snk_we_i(snk_we),
        .snk_adr_i(snk_adr), .snk_sel_i(snk_sel), .snk_dat_i(snk_dat),
        .snk_stall_o(a_stall), .snk_ack_o(a_ack),
        .src_cyc_o(a_cyc), .src_stb_o(a_stb), .src_we_o(a_we),
        .src_adr_o(a_adr), .src_sel_o(a_sel), .src_dat_o(a_dat),
        .src_stall_i(src_stall), .src_ack_i(src_ack),
        .cnt_fwd_o(a_fwd), .cnt_drop_o(a_drop)
    );

    fec_enc_tx_buffer #(.g_depth(64), .g_max_frames(2)) dut_b (
        .clk_i(clk), .rst_i(rst_b),
        .snk_cyc_i(snk_cyc), .snk_stb_i(snk_stb), .snk_we_i(snk_we),
        .snk_adr_i(snk_adr), .snk_sel_i(snk_sel), .snk_dat_i(snk_dat),
        .snk_stall_o(b_stall), .snk_ack_o(b_ack),
        .src_cyc_o(b_cyc), .src_stb_o(b_stb), .src_we_o(b_we),
        .src_adr_o(b_adr), .src_sel_o(b_sel), .src_dat_o(b_dat),
        .src_stall_i(src_stall), .src_ack_i(src_ack),
        .cnt_fwd_o(b_fwd), .cnt_drop_o(b_drop)
    );

    typedef struct packed {
        logic        first;
        logic [19:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0, n_pass = 0, n_extra = 0, ack_cnt = 0, stall_mode = 0;
    logic cyc_low_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Consumer model: samples at negedge, acks one cycle after each issued word, drives stall per mode
    initial begin : consumer
        logic issued;
        exp_t e;
        src_stall = 1'b0;
        src_ack   = 1'b0;
        forever begin
            @(negedge clk);
            issued = m_cyc & m_stb & ~src_stall;
            if (m_ack) ack_cnt++;
            if (issued) begin
                if (exp_q.size() == 0) n_extra++;
                else begin
                    e = exp_q.pop_front();
                    check("src_word", 32'(m_word), 32'(e.word));
                    if (e.first) check("gap_before_frame", 32'(cyc_low_seen), 32'd1);
                end
                cyc_low_seen = 1'b0;
            end
            if (!m_cyc) cyc_low_seen = 1'b1;
            @(posedge clk);
            #1;
            src_ack   = issued;
            src_stall = (stall_mode == 2) ? 1'b1 :
                        (stall_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input bit expect_out);
        exp_t e;
        ack_cnt = 0;
        for (int i = 0; i < len; i++) begin
            e.first = (i == 0);
            e.word  = {2'b00, (i == len - 1) ? 2'b01 : 2'b11, 16'($urandom)};
            if (expect_out) exp_q.push_back(e);
            snk_cyc = 1'b1;
            snk_stb = 1'b1;
            {snk_adr, snk_sel, snk_dat} = e.word;
            @(posedge clk);
            #1;
        end
        snk_cyc = 1'b0;
        snk_stb = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain", exp_q.size(), 0);
        wait_cycles(4);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        snk_cyc = 0; snk_stb = 0; snk_we = 1; snk_adr = 0; snk_sel = 0; snk_dat = 0;
        rst_a = 1; rst_b = 1; sel_b = 0;
        wait_cycles(3);
        @(negedge clk);
        check("rst_ack", 32'(a_ack), 0);
        check("rst_stall", 32'(a_stall), 1);
        check("rst_cyc_stb", {a_cyc, a_stb}, 0);
        check("rst_word", 32'(m_word), 0);
        check("rst_counters", {a_fwd, a_drop}, 0);
        @(posedge clk); #1;
        rst_a = 0;
        @(negedge clk);
        check("stall_after_rst", 32'(a_stall), 1);
        @(negedge clk);
        check("stall_released", 32'(a_stall), 0);
        wait_cycles(2);

        // single 64-word frame, no stall, with commit latency check
        stall_mode = 0;
        send_frame(64, 1);
        @(negedge clk);
        @(negedge clk);
        check("commit_lat_n1", 32'(m_cyc), 0);
        @(negedge clk);
        check("commit_lat_n2", {m_cyc, m_stb}, 32'b11);
        drain(200);
        check("ack_64", ack_cnt, 64);
        check("fwd_1", m_fwd, 1);
        check("drop_0", m_drop, 0);

        // 8 back-to-back frames under random stall
        stall_mode = 1;
        for (int f = 0; f < 8; f++) begin
            send_frame(32, 1);
            wait_cycles(2);
            check("ack_32", ack_cnt, 32);
        end
        drain(3000);
        stall_mode = 0;
        wait_cycles(2);
        check("fwd_9", m_fwd, 9);
        check("drop_b2b", m_drop, 0);

        // cyc pulse without stb
        snk_cyc = 1;
        wait_cycles(3);
        snk_cyc = 0;
        wait_cycles(10);
        check("pulse_fwd", m_fwd, 9);
        check("pulse_drop", m_drop, 0);
        check("pulse_no_src", n_extra, 0);

        // reset in the middle of a 100-word replay
        send_frame(100, 1);
        wait_cycles(30);
        check("mid_replay_cyc", 32'(m_cyc), 1);
        rst_a = 1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_cyc", 32'(m_cyc), 0);
        check("rst_mid_counters", {m_fwd, m_drop}, 0);
        wait_cycles(2);
        rst_a = 0;
        wait_cycles(3);
        send_frame(20, 1);
        drain(200);
        check("post_rst_fwd", m_fwd, 1);
        check("post_rst_extra", n_extra, 0);

        // switch to the small instance: RAM full drop, then descriptor FIFO full drop
        rst_a = 1;
        sel_b = 1;
        rst_b = 0;
        stall_mode = 2;
        wait_cycles(4);
        send_frame(40, 1);
        wait_cycles(2);
        check("ack_first40", ack_cnt, 40);
        send_frame(40, 0);
        wait_cycles(2);
        check("ack_dropped40", ack_cnt, 40);
        check("ram_full_drop", m_drop, 1);
        check("ram_full_fwd", m_fwd, 0);
        for (int k = 0; k < 3; k++) begin
            send_frame(4, k < 2);
            wait_cycles(2);
            check("ack_4", ack_cnt, 4);
        end
        check("desc_full_drop", m_drop, 2);
        stall_mode = 0;
        drain(500);
        check("small_fwd", m_fwd, 3);
        check("small_drop", m_drop, 2);
        check("small_extra", n_extra, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fec_enc_tx_buffer.md
# fec_enc_tx_buffer

Store-and-forward frame buffer placed directly downstream of the FEC encoder's WB fabric source. It decouples the encoder output from a stalling consumer such as the endpoint.

- It accepts complete fabric frames into a word RAM.
- It commits a frame only when the frame has fully arrived.
- It drops any frame that does not fit.
- It replays committed frames in order on a pipelined WB fabric master.

## Interface

Parameters:
- g_depth, 1024: data RAM depth in 20-bit entries (16 dat + 2 adr + 2 sel); power of two, ≥ 16.
- g_max_frames, 16: descriptor FIFO depth (committed frames held at once); power of two.

Ports:
- clk_i  in  1  single system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- snk_cyc_i, snk_stb_i, snk_we_i  in  1 each  fabric sink, driven by the encoder source.
- snk_adr_i  in  2  fabric address: 00 data, 01 OOB, 10 status, 11 user.
- snk_sel_i  in  2  byte select; 01 marks an odd final byte.
- snk_dat_i  in  16  fabric data word.
- snk_stall_o, snk_ack_o  out  1 each  sink handshake.
- src_cyc_o, src_stb_o, src_we_o  out  1 each  fabric master toward the consumer.
- src_adr_o  out  2  replayed address.
- src_sel_o  out  2  replayed byte select.
- src_dat_o  out  16  replayed data word.
- src_stall_i, src_ack_i  in  1 each  consumer handshake.
- cnt_fwd_o  out  16  frames fully forwarded; wraps at 0xFFFF→0.
- cnt_drop_o  out  16  frames dropped; wraps at 0xFFFF→0.

## Operation

Write side:
- States: IDLE, RECV, DISCARD.
- IDLE → RECV on snk_cyc_i=1. On entry, wr_ptr_tmp = wr_ptr_commit and len = 0.
- An accepted word is snk_cyc_i & snk_stb_i with snk_stall_o=0.
  - The word {adr, sel, dat} is written at wr_ptr_tmp.
  - wr_ptr_tmp and len increment.
  - snk_ack_o=1 on the next cycle. Every accepted word is acked exactly once, including in DISCARD.
- RECV → DISCARD when a word arrives and the RAM is full, i.e. wr_ptr_tmp − rd_ptr == g_depth. That word and all remaining words of the frame are acked and not stored.
- Falling snk_cyc_i in RECV:
  - len > 0 and descriptor FIFO not full: push len, set wr_ptr_commit = wr_ptr_tmp, return to IDLE.
  - len > 0 and descriptor FIFO full: drop; cnt_drop_o += 1.
  - len == 0: no commit, no count.
- Falling snk_cyc_i in DISCARD: cnt_drop_o += 1, wr_ptr_tmp rewinds to wr_ptr_commit, return to IDLE.
- snk_stall_o is 0 in all states except during reset and the single cycle after reset deassertion.

Read side:
- States: IDLE, SEND, WAIT_ACK.
- IDLE → SEND when the descriptor FIFO is non-empty. Pop len, set src_cyc_o=1.
- SEND:
  - src_stb_o=1 with the current word.
  - The word advances (rd_ptr += 1) only on a cycle where src_stall_i=0.
  - An outstanding-ack counter increments per issued word and decrements per src_ack_i.
- After len words are issued → WAIT_ACK with src_stb_o=0.
- WAIT_ACK → IDLE when the outstanding count reaches 0. src_cyc_o drops that cycle and cnt_fwd_o += 1.
- A src_ack_i while src_cyc_o=0 is ignored.
- src_we_o = src_cyc_o.

Pointers and widths:
- All pointers are clog2(g_depth)+1 bits. Full/empty use the MSB-wrap comparison; wrap-around is transparent.
- RAM space is freed word by word as rd_ptr advances.
- len is clog2(g_depth)+1 bits.

## Timing

- Reset values: snk_ack_o=0, snk_stall_o=1 (until 1 cycle after reset), src_cyc_o=0, src_stb_o=0, src_adr_o/src_sel_o/src_dat_o=0, counters=0.
- All pointers, FIFOs and states clear on reset. A frame in flight on either side is abandoned:
  - src_cyc_o drops in the reset cycle.
  - A sink frame already in progress when reset releases is treated as DISCARD until its cyc falls. It is not counted.
- Sink ack latency is exactly 1 cycle after acceptance.
- Commit latency:
  - Cycle N: snk_cyc_i is first sampled low.
  - N+1: the descriptor is visible.
  - N+2: earliest src_cyc_o=1 and src_stb_o=1 with the first word valid (RAM read is registered, with a prefetch).
- Throughput: with src_stall_i=0, one word per cycle and no bubbles inside a frame.
- Between frames: at least 1 cycle with src_cyc_o=0.
- Simultaneous events:
  - A sink commit and a source pop in the same cycle are both honoured.
  - A full condition is evaluated against rd_ptr before that cycle's read advance.

## Test plan

- 64-word frame (sel=11, last word sel=01), src_stall_i=0 → identical 64 words on src starting 2 cycles after sink cyc falls; cnt_fwd_o=1.
- 8 back-to-back 32-word frames with random src_stall_i (50%) → all frames in order, bit-exact; src_cyc_o drops between frames; cnt_fwd_o=8, cnt_drop_o=0.
- g_depth=64, src_stall_i=1 held, 40-word frame then 40-word frame → first committed, second dropped with all 40 words acked; cnt_drop_o=1. Release stall → only the first frame appears.
- g_max_frames=2, three 4-word frames with src stalled → third dropped; cnt_drop_o=1.
- Sink cyc pulse with no stb → no src activity, counters unchanged.
- rst_i asserted mid-replay of a 100-word frame → src_cyc_o=0 next edge, counters=0. The next frame replays correctly from the empty state.
